wb_master_stream: RTL

//  Pipelined Wishbone initiator.
//  - Accepts a valid/ready command stream (addr, we, wdata) and issues one Wishbone strobe per command.
//  - Returns read data on a valid/ready response stream.
//  - Drives SDRAM-style pipelined Wishbone slaves from DMA/test engines; it sits on the master side of the slave's s_wb_* port.
//  - Issues a non-flow-controlled read only when response buffering is guaranteed.
//  - Never mixes reads and writes in flight, because slaves may OR read and write acks.

---
 rtl/wb_master_stream.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/wb_master_stream.sv
// Pipelined Wishbone initiator: turns a valid/ready command stream into
// Wishbone strobes and returns read data on a first-word-fall-through
// response stream. Reads are only issued when a response slot is
// guaranteed, and reads/writes are never mixed in flight.
module wb_master_stream #(
    parameter int ADDR_BITS       = 23,
    parameter int DATA_BYTES      = 2,
    parameter int MAX_OUTSTANDING = 8,
    parameter int RSP_DEPTH       = 8
) (
    input  logic                      clk,
    input  logic                      areset,
    input  logic                      cmd_i_valid,
    output logic                      cmd_i_ready,
    input  logic [ADDR_BITS-1:0]      cmd_i_addr,
    input  logic                      cmd_i_we,
    input  logic [DATA_BYTES*8-1:0]   cmd_i_data,
    output logic                      rsp_o_valid,
    input  logic                      rsp_o_ready,
    output logic [DATA_BYTES*8-1:0]   rsp_o_data,
    output logic [ADDR_BITS-1:0]      m_wb_addr,
    output logic [DATA_BYTES*8-1:0]   m_wb_dat_m2s,
    input  logic [DATA_BYTES*8-1:0]   m_wb_dat_s2m,
    output logic                      m_wb_we,
    output logic                      m_wb_stb,
    output logic                      m_wb_cyc,
    input  logic                      m_wb_ack,
    input  logic                      m_wb_stall,
    output logic                      busy,
    output logic                      err
);

    localparam int DW    = DATA_BYTES * 8;
    localparam int IF_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int RC_W  = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int SUM_W = RC_W + 1;

    localparam logic [IF_W-1:0]  MAX_IF   = IF_W'(MAX_OUTSTANDING);
    localparam logic [SUM_W-1:0] RSP_LIM  = SUM_W'(RSP_DEPTH);

    // Issue register (one strobe slot)
    logic [ADDR_BITS-1:0] issue_addr_p0;
    logic [DW-1:0]        issue_dat_p0;
    logic                 issue_we_p0;
    logic                 issue_vld_p0;

    // Bookkeeping
    logic [IF_W-1:0]      in_flight;
    logic                 we_dir;
    logic                 err_q;

    // Response FIFO
    logic [DW-1:0]        rsp_mem [RSP_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [RC_W-1:0]      rsp_count;

    logic                 slot_free;
    logic                 credit_ok;
    logic                 dir_ok;
    logic                 rsp_ok;
    logic [SUM_W-1:0]     rd_credit_used;
    logic                 accept;
    logic                 ack_ok;
    logic                 push;
    logic                 pop;

    // Readiness is derived only from registered counts, so a same-cycle
    // ack or pop frees credit one cycle later.
    always_comb begin
        rd_credit_used = SUM_W'(in_flight) + SUM_W'(rsp_count);
        slot_free      = !issue_vld_p0 || !m_wb_stall;
        credit_ok      = in_flight < MAX_IF;
        dir_ok         = (in_flight == '0) || (cmd_i_we == we_dir);
        rsp_ok         = cmd_i_we || (rd_credit_used < RSP_LIM);
        cmd_i_ready    = slot_free && credit_ok && dir_ok && rsp_ok;
        accept         = cmd_i_valid && cmd_i_ready;
        ack_ok         = m_wb_ack && (in_flight != '0);
        push           = ack_ok && !we_dir;
        pop            = rsp_o_valid && rsp_o_ready;
    end

    assign m_wb_addr    = issue_addr_p0;
    assign m_wb_dat_m2s = issue_dat_p0;
    assign m_wb_we      = issue_we_p0;
    assign m_wb_stb     = issue_vld_p0;
    assign m_wb_cyc     = (in_flight != '0);
    assign busy         = (in_flight != '0);
    assign err          = err_q;
    assign rsp_o_valid  = (rsp_count != '0);
    assign rsp_o_data   = rsp_mem[rd_ptr];

    // Strobe valid: set on accept, dropped once the slave takes it.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            issue_vld_p0 <= 1'b0;
        end else if (accept) begin
            issue_vld_p0 <= 1'b1;
        end else if (!m_wb_stall) begin
            issue_vld_p0 <= 1'b0;
        end
    end

    // Strobe payload: only changes on accept, so it holds through stalls.
    always_ff @(posedge clk) begin
        if (accept) begin
            issue_addr_p0 <= cmd_i_addr;
            issue_dat_p0  <= cmd_i_data;
            issue_we_p0   <= cmd_i_we;
        end
    end

    // Outstanding count, bus direction and sticky stray-ack error.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            in_flight <= '0;
            we_dir    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (accept && !ack_ok) begin
                in_flight <= in_flight + IF_W'(1);
            end else if (!accept && ack_ok) begin
                in_flight <= in_flight - IF_W'(1);
            end
            if (accept) begin
                we_dir <= cmd_i_we;
            end
            if (m_wb_ack && (in_flight == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Response storage; read credit guarantees a free slot on every push.
    always_ff @(posedge clk) begin
        if (push) begin
            rsp_mem[wr_ptr] <= m_wb_dat_s2m;
        end
    end

    // Response FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rsp_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                rsp_count <= rsp_count + RC_W'(1);
            end else if (!push && pop) begin
                rsp_count <= rsp_count - RC_W'(1);
            end
        end
    end

endmodule
